// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD byte constants, writer FSM states and BCD-to-ASCII helper
package lcd_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE2_BASE = 8'h40;
  localparam logic [3:0] ITEM_LAST = 4'd8;
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_LOW, WAIT_HIGH} state_t;
  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    return d > 4'd9 ? ASCII_QMARK : ASCII_ZERO | {4'd0, d};
  endfunction
endpackage

// File: rtl/lcd_time_writer_if.sv
// lcd_time_writer_if: writer-to-lcd_disp_interface handshake (data, send_data, ins_data out; ready back)
interface lcd_time_writer_if;
  logic [7:0] data;
  logic send_data;
  logic ins_data;
  logic ready;
  modport master(output data, output send_data, output ins_data, input ready);
  modport slave(input data, input send_data, input ins_data, output ready);
endinterface

// File: rtl/lcd_time_item_sel.sv
// lcd_time_item_sel: item index 0-8 + BCD snapshot -> LCD byte (DDRAM address or HH:MM:SS char) and is_char (RS)
module lcd_time_item_sel import lcd_pkg::*; #(
  parameter int START_COL = 4
) (
  input  logic [3:0]  idx,
  input  logic [23:0] snap,
  output logic [7:0]  item_byte,
  output logic        is_char
);
  logic [3:0] digit;
  always_comb begin
    case (idx)
      4'd1: digit = snap[23:20];
      4'd2: digit = snap[19:16];
      4'd4: digit = snap[15:12];
      4'd5: digit = snap[11:8];
      4'd7: digit = snap[7:4];
      default: digit = snap[3:0];
    endcase
    is_char = idx != 4'd0;
    item_byte = !is_char ? (LCD_SET_DDRAM | {4'd0, 4'(START_COL)}) :
                (idx == 4'd3 || idx == 4'd6) ? ASCII_COLON : bcd_ascii(digit);
  end
endmodule

// File: rtl/lcd_time_writer.sv
// lcd_time_writer: snapshots time_bcd on update and writes address + 8 chars through lcd (master), reporting busy/frame_done/err
module lcd_time_writer import lcd_pkg::*; #(
  parameter int START_COL = 4,
  parameter int ACK_TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [23:0]         time_bcd,
  input  logic                update,
  lcd_time_writer_if.master   lcd,
  output logic                busy,
  output logic                frame_done,
  output logic                err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [23:0] snap, snap_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] item_byte, data_n;
  logic is_char, ins_n, send_n, pending, pending_n, busy_n, frame_done_n, err_n;
  lcd_time_item_sel #(.START_COL(START_COL)) u_sel (
    .idx(idx),
    .snap(snap),
    .item_byte(item_byte),
    .is_char(is_char)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      snap <= '0;
      cnt <= '0;
      pending <= 1'b0;
      lcd.data <= '0;
      lcd.ins_data <= 1'b0;
      lcd.send_data <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      snap <= snap_n;
      cnt <= cnt_n;
      pending <= pending_n;
      lcd.data <= data_n;
      lcd.ins_data <= ins_n;
      lcd.send_data <= send_n;
      busy <= busy_n;
      frame_done <= frame_done_n;
      err <= err_n;
    end
  always_comb begin
    state_n = state;
    idx_n = idx;
    snap_n = snap;
    cnt_n = cnt;
    pending_n = pending | update;
    data_n = lcd.data;
    ins_n = lcd.ins_data;
    send_n = 1'b0;
    busy_n = busy;
    frame_done_n = 1'b0;
    err_n = err;
    case (state)
      IDLE:
        if (update || pending) begin
          state_n = LOAD;
          snap_n = time_bcd;
          pending_n = 1'b0;
          err_n = 1'b0;
          idx_n = '0;
          busy_n = 1'b1;
        end
      LOAD:
        if (lcd.ready) begin
          state_n = STROBE;
          data_n = item_byte;
          ins_n = is_char;
          send_n = 1'b1;
        end
      STROBE: begin
        cnt_n = '0;
        state_n = WAIT_LOW;
      end
      WAIT_LOW:
        if (!lcd.ready) state_n = WAIT_HIGH;
        else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          err_n = 1'b1;
          busy_n = 1'b0;
          state_n = IDLE;
        end else cnt_n = cnt + CW'(1);
      WAIT_HIGH:
        if (lcd.ready) begin
          if (idx == ITEM_LAST) begin
            frame_done_n = 1'b1;
            busy_n = 1'b0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 4'd1;
            state_n = LOAD;
          end
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lcd_time_writer.sv
// tb_lcd_time_writer: random/directed frames against a character-table model with an LCD ready model
module tb_lcd_time_writer;
  localparam int START_COL = 4;
  localparam int ACK = 50;
  logic clk = 1'b0;
  logic rst, update, busy, frame_done, err;
  logic [23:0] time_bcd;
  logic rdy = 1'b1;
  logic drop = 1'b0;
  logic send_prev = 1'b0;
  logic no_ack;
  int hold = 0;
  int restore = 20;
  int fd_cnt = 0;
  int nf = 0;
  int checks = 0;
  int errors = 0;
  logic [8:0] got_q[$];
  lcd_time_writer_if lcd();
  assign lcd.ready = rdy;
  lcd_time_writer #(.START_COL(START_COL), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk),
    .rst(rst),
    .time_bcd(time_bcd),
    .update(update),
    .lcd(lcd.master),
    .busy(busy),
    .frame_done(frame_done),
    .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (drop) begin
      rdy = 1'b0;
      hold = restore;
      drop = 1'b0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) rdy = 1'b1;
    end
    if (lcd.send_data) begin
      got_q.push_back({lcd.ins_data, lcd.data});
      if (!no_ack) drop = 1'b1;
    end
    if (lcd.send_data && send_prev) begin
      checks++;
      errors++;
      $error("FAIL double_send: send_data high 2 cycles, required 1");
    end
    send_prev = lcd.send_data;
    if (frame_done) fd_cnt++;
  end
  function automatic logic [8:0] exp_item(input logic [23:0] t, input int i);
    logic [7:0] txt[9];
    int d;
    txt[0] = 8'h80 | 8'(START_COL % 16);
    txt[3] = ":";
    txt[6] = ":";
    for (int k = 0; k < 6; k++) begin
      d = int'(t[23-4*k -: 4]);
      txt[k + k / 2 + 1] = d > 9 ? "?" : 8'(48 + d);
    end
    return {i != 0, txt[i]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic [23:0] t);
    @(negedge clk);
    time_bcd = t;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask
  task automatic wait_fd(input int n);
    for (int i = 0; i < 3000 && fd_cnt < n; i++) @(negedge clk);
    chk($sformatf("frame_done_%0d_seen", n), 32'(fd_cnt >= n), 1);
  endtask
  task automatic wait_items(input int n);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) @(negedge clk);
    chk($sformatf("items_%0d_seen", n), 32'(got_q.size() >= n), 1);
  endtask
  task automatic check_frame(input logic [23:0] t, input string tag);
    chk({tag, "_len"}, 32'(got_q.size() >= 9), 1);
    for (int i = 0; i < 9 && got_q.size() > 0; i++)
      chk($sformatf("%s_item%0d", tag, i), 32'(got_q.pop_front()), 32'(exp_item(t, i)));
  endtask
  initial begin
    logic [23:0] t, r;
    int el;
    rst = 1'b1;
    update = 1'b0;
    time_bcd = '0;
    no_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(lcd.data), 0);
    chk("rst_send", 32'(lcd.send_data), 0);
    chk("rst_ins", 32'(lcd.ins_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    time_bcd = 24'h123459;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk("busy_start", 32'(busy), 1);
    @(negedge clk);
    chk("first_strobe", 32'(lcd.send_data), 1);
    chk("first_byte", 32'(lcd.data), 32'h84);
    chk("first_rs", 32'(lcd.ins_data), 0);
    wait_fd(++nf);
    check_frame(24'h123459, "basic");
    chk("basic_fd_count", 32'(fd_cnt), 32'(nf));
    @(negedge clk);
    chk("basic_busy_after", 32'(busy), 0);
    pulse(24'h123459);
    wait_items(3);
    time_bcd = '0;
    wait_fd(++nf);
    check_frame(24'h123459, "tear");
    t = 24'($urandom);
    r = 24'($urandom);
    pulse(t);
    wait_items(2);
    pulse(r);
    repeat (10) @(negedge clk);
    pulse(r);
    repeat (10) @(negedge clk);
    pulse(r);
    wait_fd(++nf);
    check_frame(t, "coal_first");
    wait_fd(++nf);
    check_frame(r, "coal_second");
    repeat (400) @(negedge clk);
    chk("coal_no_third_fd", 32'(fd_cnt), 32'(nf));
    chk("coal_no_third_items", 32'(got_q.size()), 0);
    chk("coal_idle", 32'(busy), 0);
    pulse(24'h2A0000);
    wait_fd(++nf);
    chk("bad_digit_h10", 32'(got_q[1]), 32'h132);
    chk("bad_digit_h1", 32'(got_q[2]), 32'h13F);
    check_frame(24'h2A0000, "bad_digit");
    t = 24'($urandom);
    r = 24'($urandom);
    pulse(t);
    for (int i = 0; i < 3000 && !frame_done; i++) @(negedge clk);
    time_bcd = r;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_fd(++nf);
    check_frame(t, "coinc_first");
    wait_fd(++nf);
    check_frame(r, "coinc_second");
    for (int n = 0; n < 4; n++) begin
      restore = $urandom_range(1, 20);
      t = 24'($urandom);
      pulse(t);
      wait_fd(++nf);
      check_frame(t, $sformatf("rand%0d", n));
    end
    restore = 20;
    repeat (30) @(negedge clk);
    no_ack = 1'b1;
    pulse(24'h235959);
    for (int i = 0; i < 20 && !lcd.send_data; i++) @(negedge clk);
    chk("tmo_strobe", 32'(lcd.send_data), 1);
    el = 0;
    while (!err && el < 200) begin
      @(negedge clk);
      el++;
    end
    chk("tmo_cycles", 32'(el), 32'(ACK + 1));
    chk("tmo_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 1);
    chk("tmo_no_fd", 32'(fd_cnt), 32'(nf));
    got_q.delete();
    no_ack = 1'b0;
    t = 24'($urandom);
    pulse(t);
    chk("tmo_err_cleared", 32'(err), 0);
    wait_fd(++nf);
    check_frame(t, "after_tmo");
    t = 24'($urandom);
    pulse(t);
    wait_items(6);
    repeat (4) @(negedge clk);
    pulse(t);
    chk("pre_rst_data", 32'(lcd.data), 32'(exp_item(t, 5) & 9'hFF));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(lcd.data), 0);
    chk("mid_rst_ins", 32'(lcd.ins_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_send", 32'(lcd.send_data), 0);
    #1 rst = 1'b0;
    got_q.delete();
    repeat (400) @(negedge clk);
    chk("post_rst_no_items", 32'(got_q.size()), 0);
    chk("post_rst_no_fd", 32'(fd_cnt), 32'(nf));
    chk("post_rst_idle", 32'(busy), 0);
    t = 24'($urandom);
    pulse(t);
    wait_fd(++nf);
    check_frame(t, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_time_writer.md
Name: lcd_time_writer

Overview:
- Upstream feeder for lcd_disp_interface: converts a BCD time value (HH:MM:SS) into a 9-item LCD write sequence and drives the interface's data/send_data/ins_data/ready handshake.
- Sequence: one Set-DDRAM-address instruction, then 8 ASCII characters.
- Sits between the bcd_counter chain and lcd_disp_interface, replacing ad-hoc sequencing in the top level.

Parameters:
- START_COL, 4, display column (0-15) of the first character on line 1.
- ACK_TIMEOUT, 1000000, cycles allowed for lcd ready to drop after a send pulse before the frame aborts.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- time_bcd  in  24  {h10,h1,m10,m1,s10,s1}, 4-bit BCD digits, h10 at [23:20].
- update  in  1  single-cycle request to redraw the time.
- ready  in  1  from lcd_disp_interface; high when idle.
- data  out  8  byte to lcd_disp_interface.
- send_data  out  1  one-cycle send strobe.
- ins_data  out  1  RS value: 1 = character, 0 = instruction.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last item is accepted.
- err  out  1  sticky timeout flag; cleared at next frame start.

Behaviour:
- Reset (async) values: data=0, send_data=0, ins_data=0, busy=0, frame_done=0, err=0, state=IDLE, pending=0, item index=0, snapshot=0.
- Items, index 0-8:
  - 0: instruction 0x80 | START_COL (ins_data=0).
  - 1-8 (ins_data=1): h10, h1, ':'(0x3A), m10, m1, ':', s10, s1.
  - Digit d maps to 0x30+d; d>9 maps to '?' (0x3F).
- FSM states: IDLE, LOAD, STROBE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - On update or pending: latch time_bcd into snapshot, clear pending and err, set index=0, busy=1, go to LOAD.
  - The snapshot is taken once per frame, so mid-frame changes to time_bcd never tear the display.
- LOAD:
  - When ready=1, present data/ins_data for the current index and go to STROBE.
  - data/ins_data stay stable from LOAD until the item is accepted.
- STROBE:
  - send_data=1 for exactly this one cycle.
  - Clear the timeout counter, go to WAIT_LOW.
- WAIT_LOW:
  - On ready=0, go to WAIT_HIGH.
  - If the counter reaches ACK_TIMEOUT first: set err=1, busy=0, go to IDLE. frame_done is not pulsed.
- WAIT_HIGH:
  - On ready=1: if index==8, pulse frame_done and set busy=0, then go to IDLE. Otherwise index+1 and go to LOAD.
  - No timeout here; the interface always completes.
- Latency, IDLE to first strobe: 2 cycles when ready is already high.
- send_data is never re-asserted until ready has been seen low then high. This guards against a double-send, since lcd ready drops one cycle after accept.
- update while busy: set pending=1. Multiple requests coalesce into one pending flag. The next frame starts the cycle after frame_done (or after a timeout abort) and uses a fresh snapshot.
- update in the same cycle as frame_done: treated as pending, so a new frame follows.
- ready low in IDLE/LOAD (lcd still initialising): the FSM waits in LOAD indefinitely, with no timeout.
- Reset asserted mid-frame: all outputs return to reset values immediately. send_data drops asynchronously and pending is lost.
- START_COL > 15 is a configuration error. Only the low 4 bits are used.

Decomposition:
- Package lcd_pkg:
  - Constants ASCII_ZERO=0x30, ASCII_COLON=0x3A, ASCII_QMARK=0x3F, LCD_SET_DDRAM=0x80, LCD_LINE2_BASE=0x40.
  - FSM state encoding.
  - ITEM_LAST=8.
- Sub-module lcd_time_item_sel: combinational (index, snapshot, START_COL) -> (byte, is_char). It holds the BCD-to-ASCII mapping and keeps the FSM free of table logic.

Test Plan:
- Reset release, ready tied high with a model that drops ready 1 cycle after send and restores it 20 cycles later. update with time_bcd=0x123459 -> 9 strobes with bytes 0x84, 0x31, 0x32, 0x3A, 0x33, 0x34, 0x3A, 0x35, 0x39; ins_data 0, then 1×8; one frame_done; busy low afterwards.
- Change time_bcd to 0x000000 during item 3 -> the remaining bytes still come from 0x123459.
- Three update pulses during one frame -> exactly one extra frame follows, with the new snapshot.
- time_bcd=0x2A0000 -> bytes 2 and 3 are 0x32 and 0x3F.
- Model never drops ready after a strobe, with ACK_TIMEOUT=50 -> err=1 after 50 cycles, busy=0, no frame_done; the next update clears err.
- Assert rst during WAIT_HIGH of item 5 -> outputs zero immediately; after release, no strobe occurs until a new update.
